// File: rtl/transformer_stream_core.sv
// Streaming N x N matrix core: buffers one frame, waits a fixed compute latency,
// then drains it through one of four per-frame element transforms.
module transformer_stream_core #(
  parameter int unsigned MATRIX_SIZE    = 4,
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned COMPUTE_CYCLES = 33
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            cfg_mode,
  input  logic [3:0]            cfg_shift,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done,
  output logic                  err_last
);

  localparam int unsigned DEPTH  = MATRIX_SIZE * MATRIX_SIZE;
  localparam int unsigned IDX_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = (COMPUTE_CYCLES > 1) ? $clog2(COMPUTE_CYCLES) : 1;
  localparam int unsigned WIDE_W = DATA_WIDTH + 15;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CMP_LAST = CNT_W'(COMPUTE_CYCLES - 1);

  typedef enum logic [1:0] {S_LOAD, S_COMPUTE, S_DRAIN} state_t;

  state_t                state, state_nxt;
  logic [IDX_W-1:0]      wr_idx, rd_idx, src_idx;
  logic [CNT_W-1:0]      cmp_cnt;
  logic [1:0]            mode_q;
  logic [3:0]            shift_q;
  logic [DATA_WIDTH-1:0] buffer [DEPTH];
  logic [DATA_WIDTH-1:0] elem, result, sat_val;
  logic [WIDE_W-1:0]     wide;
  logic                  in_hs, out_hs, shift_fits;

  assign in_ready  = (state == S_LOAD);
  assign out_valid = (state == S_DRAIN);
  assign busy      = (state == S_COMPUTE) || (state == S_DRAIN);
  assign out_last  = out_valid && (rd_idx == LAST_IDX);
  assign in_hs     = in_valid && in_ready;
  assign out_hs    = out_valid && out_ready;

  always_comb begin
    state_nxt = state;
    case (state)
      S_LOAD:    if (in_hs && wr_idx == LAST_IDX) state_nxt = S_COMPUTE;
      S_COMPUTE: if (cmp_cnt == CMP_LAST)         state_nxt = S_DRAIN;
      S_DRAIN:   if (out_hs && rd_idx == LAST_IDX) state_nxt = S_LOAD;
      default:   state_nxt = S_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_LOAD;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_idx   <= '0;
      rd_idx   <= '0;
      cmp_cnt  <= '0;
      mode_q   <= '0;
      shift_q  <= '0;
      done     <= 1'b0;
      err_last <= 1'b0;
    end else begin
      done     <= 1'b0;
      err_last <= 1'b0;
      if (in_hs) begin
        if (wr_idx == '0) begin
          mode_q  <= cfg_mode;
          shift_q <= cfg_shift;
        end
        // Element count alone frames the matrix; in_last is only audited.
        err_last <= in_last ^ (wr_idx == LAST_IDX);
        wr_idx   <= (wr_idx == LAST_IDX) ? '0 : wr_idx + 1'b1;
      end
      if (state == S_COMPUTE) begin
        cmp_cnt <= (cmp_cnt == CMP_LAST) ? '0 : cmp_cnt + 1'b1;
        rd_idx  <= '0;
      end
      if (out_hs) begin
        rd_idx <= (rd_idx == LAST_IDX) ? '0 : rd_idx + 1'b1;
        done   <= (rd_idx == LAST_IDX);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (in_hs) buffer[wr_idx] <= in_data;
  end

  always_comb begin
    src_idx = rd_idx;
    if (mode_q == 2'b01)
      src_idx = IDX_W'((32'(rd_idx) % MATRIX_SIZE) * MATRIX_SIZE + 32'(rd_idx) / MATRIX_SIZE);
    elem = buffer[src_idx];
    // Shift in a widened sign-extended copy; in range iff the bits above the result sign all match it.
    wide       = {{15{elem[DATA_WIDTH-1]}}, elem} << shift_q;
    shift_fits = (&wide[WIDE_W-1:DATA_WIDTH-1]) || !(|wide[WIDE_W-1:DATA_WIDTH-1]);
    sat_val    = elem[DATA_WIDTH-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                    : {1'b0, {(DATA_WIDTH-1){1'b1}}};
    case (mode_q)
      2'b10:   result = elem[DATA_WIDTH-1] ? '0 : elem;
      2'b11:   result = shift_fits ? wide[DATA_WIDTH-1:0] : sat_val;
      default: result = elem;
    endcase
    out_data = out_valid ? result : '0;
  end

endmodule
